fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h00000000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rs_i  input  1  reset, synchronous, active-low (0 = reset).
REQ-004 branch_i  input  1  redirect request from execute stage.
REQ-005 branch_addr_i  input  32  redirect target.
REQ-006 mem_req_o  output  1  instruction memory read request.
REQ-007 mem_addr_o  output  32  word-aligned read address.
REQ-008 mem_gnt_i  input  1  memory accepted the request this cycle.
REQ-009 mem_rvalid_i  input  1  read data valid.
REQ-010 mem_rdata_i  input  32  read data.
REQ-011 instr_o  output  32  fetched instruction, feeds decode-stage 32-bit pipeline register.
REQ-012 pc_o  output  32  address of instr_o.
REQ-013 instr_valid_o  output  1  instr_o/pc_o valid.
REQ-014 instr_ready_i  input  1  downstream register accepts instr_o this cycle.

Function
REQ-015 The block SHALL implement states REQ, WAIT, OUT, DRAIN.
REQ-016 REQ: mem_req_o=1, mem_addr_o=pc; mem_gnt_i=1 -> WAIT; else stay.
REQ-017 WAIT: mem_req_o=0; mem_rvalid_i=1 -> instr_o<=mem_rdata_i, pc_o<=pc, -> OUT; else stay.
REQ-018 OUT: instr_valid_o=1, instr_o/pc_o held stable; instr_ready_i=1 -> pc<=pc+4, -> REQ.
REQ-019 DRAIN: mem_req_o=0, instr_valid_o=0; mem_rvalid_i=1 -> response discarded, -> REQ.
REQ-020 instr_valid_o SHALL be 1 only in OUT; mem_req_o only in REQ; mem_addr_o SHALL always equal pc.
REQ-021 pc+4 SHALL be modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-022 Redirect: branch_i=1 in any state SHALL load pc<={branch_addr_i[31:2],2'b00} next cycle.
REQ-023 branch_i in REQ: -> REQ with new pc; a grant in the same cycle SHALL move to DRAIN instead.
REQ-024 branch_i in WAIT without mem_rvalid_i: -> DRAIN; with mem_rvalid_i same cycle: data discarded, -> REQ.
REQ-025 branch_i in OUT (with or without instr_ready_i): instruction dropped, instr_valid_o=0 next cycle, no +4, -> REQ.
REQ-026 branch_i in DRAIN: pc updated, stay DRAIN until mem_rvalid_i.
REQ-027 mem_gnt_i outside REQ and mem_rvalid_i outside WAIT/DRAIN SHALL be ignored.
REQ-028 At most one outstanding memory request at any time.
REQ-029 Latency: grant-cycle N, rvalid-cycle M -> instr_valid_o=1 from cycle M+1.

Reset
REQ-030 rs_i=0 at a rising edge SHALL force state=REQ, pc=RESET_PC, instr_o=0, pc_o=RESET_PC, instr_valid_o=0, overriding all other inputs.
REQ-031 While rs_i=0, mem_req_o SHALL be 0; first request issued in the first cycle with rs_i=1.
REQ-032 Reset mid-transaction SHALL abandon the pending request; a stale mem_rvalid_i after reset in REQ SHALL be ignored.

Verification
REQ-033 Reset, gnt immediate, rvalid 1 cycle later with 32'h00500093, ready=1 -> pc_o=0, instr_o=32'h00500093 valid one cycle; next mem_addr_o=32'h00000004.
REQ-034 Backpressure: ready=0 for 5 cycles in OUT -> instr_o, pc_o stable, valid=1, mem_req_o=0 throughout.
REQ-035 branch_i=1, branch_addr_i=32'h00001003 while in WAIT -> DRAIN; response 32'hDEADBEEF never appears on instr_o; next mem_addr_o=32'h00001000.
REQ-036 branch_i and instr_ready_i both 1 in OUT with target 32'h00000200 -> valid drops, next mem_addr_o=32'h00000200, not pc+4.
REQ-037 RESET_PC=32'hFFFFFFFC, one fetch accepted -> next mem_addr_o=32'h00000000.
REQ-038 rs_i=0 asserted during WAIT, rvalid arrives after release -> state REQ, mem_addr_o=RESET_PC, stale data ignored, instr_valid_o=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: memory read channel plus the decode-side output.
interface fetch_unit_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        instr_ready_i;

    // Fetch unit side
    modport master (
        output mem_req_o, mem_addr_o, instr_o, pc_o, instr_valid_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i
    );

    // Memory / decode side
    modport slave (
        input  mem_req_o, mem_addr_o, instr_o, pc_o, instr_valid_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with branch redirect.
// Sequence per instruction: request (REQ) -> wait for data (WAIT) -> present
// to decode (OUT). A redirect that leaves a granted read in flight parks in
// DRAIN until that stale response returns.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rs_i,
    input  logic         branch_i,
    input  logic [31:0]  branch_addr_i,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_OUT   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        valid;
    logic [31:0] target;
    logic        unused_align;

    // Redirect targets are forced to a word boundary; low bits are dropped.
    assign target       = {branch_addr_i[31:2], 2'b00};
    assign unused_align = ^branch_addr_i[1:0];

    // Request is qualified by reset so nothing is issued while rs_i is low,
    // yet the first request appears in the very first cycle after release.
    assign bus.mem_req_o     = (state == ST_REQ) && rs_i;
    assign bus.mem_addr_o    = pc;
    assign bus.instr_o       = instr;
    assign bus.pc_o          = pc_out;
    assign bus.instr_valid_o = valid;

    // Fetch state machine, program counter and output register.
    always_ff @(posedge clk) begin
        if (!rs_i) begin
            state  <= ST_REQ;
            pc     <= RESET_PC;
            instr  <= '0;
            pc_out <= RESET_PC;
            valid  <= 1'b0;
        end else begin
            case (state)
                ST_REQ: begin
                    if (branch_i) begin
                        pc    <= target;
                        state <= bus.mem_gnt_i ? ST_DRAIN : ST_REQ;
                    end else if (bus.mem_gnt_i) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (branch_i) begin
                        pc    <= target;
                        state <= bus.mem_rvalid_i ? ST_REQ : ST_DRAIN;
                    end else if (bus.mem_rvalid_i) begin
                        instr  <= bus.mem_rdata_i;
                        pc_out <= pc;
                        valid  <= 1'b1;
                        state  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (branch_i) begin
                        pc    <= target;
                        valid <= 1'b0;
                        state <= ST_REQ;
                    end else if (bus.instr_ready_i) begin
                        pc    <= pc + 32'd4;
                        valid <= 1'b0;
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (branch_i) begin
                        pc <= target;
                    end
                    if (bus.mem_rvalid_i) begin
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit.
module tb_fetch_unit;

    typedef struct {
        logic        rs;
        logic        br;
        logic [31:0] baddr;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rs0, br0, rs1, br1;
    logic [31:0] baddr0, baddr1;
    int          total = 0;
    int          bad = 0;
    vec_t        vecs[$];

    fetch_unit_if bus0 ();
    fetch_unit_if bus1 ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rs_i(rs0), .branch_i(br0), .branch_addr_i(baddr0), .bus(bus0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rs_i(rs1), .branch_i(br1), .branch_addr_i(baddr1), .bus(bus1)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rs, input logic br, input logic [31:0] baddr,
        input logic gnt, input logic rv, input logic [31:0] rdata, input logic rdy,
        input logic req, input logic [31:0] addr, input logic vld,
        input logic [31:0] instr, input logic [31:0] pc);
        vec_t v;
        v.rs = rs; v.br = br; v.baddr = baddr; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.rdy = rdy; v.req = req; v.addr = addr; v.vld = vld;
        v.instr = instr; v.pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s row=%0d got=%h exp=%h", name, row, act, exp);
        end
    endtask

    initial begin
        // rs br baddr gnt rv rdata rdy | req addr vld instr pc
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h0,0,32'h0,32'h0));                      // 0 reset
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h0,0,32'h0,32'h0));                      // 1 REQ, gnt
        vecs.push_back(mk(1,0,0,0,1,32'h00500093,0, 0,32'h0,0,32'h0,32'h0));           // 2 WAIT, rvalid
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h0,1,32'h00500093,32'h0));               // 3 OUT, ready
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h4,0,32'h00500093,32'h0));               // 4 REQ pc+4, no gnt
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h4,0,32'h00500093,32'h0));               // 5 gnt
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h4,0,32'h00500093,32'h0));               // 6 WAIT idle
        vecs.push_back(mk(1,0,0,0,1,32'h00A00113,0, 0,32'h4,0,32'h00500093,32'h0));    // 7 rvalid
        for (int i = 0; i < 5; i++)                                                     // 8-12 backpressure, stray gnt
            vecs.push_back(mk(1,0,0,1,0,0,0, 0,32'h4,1,32'h00A00113,32'h4));
        vecs.push_back(mk(1,0,0,0,0,0,1, 0,32'h4,1,32'h00A00113,32'h4));               // 13 ready
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h8,0,32'h00A00113,32'h4));               // 14 gnt
        vecs.push_back(mk(1,1,32'h00001003,0,0,0,0, 0,32'h8,0,32'h00A00113,32'h4));    // 15 branch in WAIT
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,32'h1000,0,32'h00A00113,32'h4));            // 16 DRAIN idle
        vecs.push_back(mk(1,0,0,0,1,32'hDEADBEEF,0, 0,32'h1000,0,32'h00A00113,32'h4)); // 17 stale resp
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h1000,0,32'h00A00113,32'h4));            // 18 gnt
        vecs.push_back(mk(1,0,0,0,1,32'h00000013,0, 0,32'h1000,0,32'h00A00113,32'h4)); // 19 rvalid
        vecs.push_back(mk(1,1,32'h00000200,0,0,0,1, 0,32'h1000,1,32'h00000013,32'h1000)); // 20 branch+ready in OUT
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h200,0,32'h00000013,32'h1000));          // 21 REQ at target
        vecs.push_back(mk(1,1,32'h00000300,1,0,0,0, 1,32'h200,0,32'h00000013,32'h1000)); // 22 branch+gnt in REQ
        vecs.push_back(mk(1,1,32'h00000407,0,0,0,0, 0,32'h300,0,32'h00000013,32'h1000)); // 23 branch in DRAIN
        vecs.push_back(mk(1,0,0,0,1,32'hCAFEF00D,0, 0,32'h404,0,32'h00000013,32'h1000)); // 24 drain resp
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h404,0,32'h00000013,32'h1000));          // 25 gnt
        vecs.push_back(mk(1,1,32'h00000800,0,1,32'h11111111,0, 0,32'h404,0,32'h00000013,32'h1000)); // 26 branch+rvalid
        vecs.push_back(mk(1,0,0,1,0,0,0, 1,32'h800,0,32'h00000013,32'h1000));          // 27 gnt
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h800,0,32'h00000013,32'h1000));          // 28 reset in WAIT
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,32'h0,0,32'h0,32'h0));                      // 29 held in reset
        vecs.push_back(mk(1,0,0,0,1,32'hBADBAD00,0, 1,32'h0,0,32'h0,32'h0));           // 30 stale rvalid in REQ
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,32'h0,0,32'h0,32'h0));                      // 31 still REQ

        rs0 = 1'b0; br0 = 1'b0; baddr0 = '0;
        rs1 = 1'b0; br1 = 1'b0; baddr1 = '0;
        bus0.mem_gnt_i = 1'b0; bus0.mem_rvalid_i = 1'b0; bus0.mem_rdata_i = '0; bus0.instr_ready_i = 1'b0;
        bus1.mem_gnt_i = 1'b0; bus1.mem_rvalid_i = 1'b0; bus1.mem_rdata_i = '0; bus1.instr_ready_i = 1'b0;
        repeat (2) @(posedge clk);

        for (int r = 0; r < vecs.size(); r++) begin
            @(negedge clk);
            rs0 = vecs[r].rs; br0 = vecs[r].br; baddr0 = vecs[r].baddr;
            bus0.mem_gnt_i = vecs[r].gnt; bus0.mem_rvalid_i = vecs[r].rv;
            bus0.mem_rdata_i = vecs[r].rdata; bus0.instr_ready_i = vecs[r].rdy;
            #1;
            check("mem_req", r, {31'b0, bus0.mem_req_o}, {31'b0, vecs[r].req});
            check("mem_addr", r, bus0.mem_addr_o, vecs[r].addr);
            check("instr_valid", r, {31'b0, bus0.instr_valid_o}, {31'b0, vecs[r].vld});
            check("instr", r, bus0.instr_o, vecs[r].instr);
            check("pc", r, bus0.pc_o, vecs[r].pc);
            // second instance sits in reset throughout the table
            check("wrap_rst_req", r, {31'b0, bus1.mem_req_o}, 32'h0);
        end

        // Wrap-around of pc+4 from the top word address.
        @(negedge clk);
        rs1 = 1'b0; #1;
        check("wrap_rst_addr", 100, bus1.mem_addr_o, 32'hFFFF_FFFC);
        check("wrap_rst_pc", 100, bus1.pc_o, 32'hFFFF_FFFC);
        @(negedge clk);
        rs1 = 1'b1; bus1.mem_gnt_i = 1'b1; #1;
        check("wrap_req", 101, {31'b0, bus1.mem_req_o}, 32'h1);
        check("wrap_addr", 101, bus1.mem_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        bus1.mem_gnt_i = 1'b0; bus1.mem_rvalid_i = 1'b1; bus1.mem_rdata_i = 32'h0010_0073; #1;
        check("wrap_wait_req", 102, {31'b0, bus1.mem_req_o}, 32'h0);
        @(negedge clk);
        bus1.mem_rvalid_i = 1'b0; bus1.instr_ready_i = 1'b1; #1;
        check("wrap_valid", 103, {31'b0, bus1.instr_valid_o}, 32'h1);
        check("wrap_instr", 103, bus1.instr_o, 32'h0010_0073);
        check("wrap_pc", 103, bus1.pc_o, 32'hFFFF_FFFC);
        @(negedge clk);
        bus1.instr_ready_i = 1'b0; #1;
        check("wrap_next_req", 104, {31'b0, bus1.mem_req_o}, 32'h1);
        check("wrap_next_addr", 104, bus1.mem_addr_o, 32'h0000_0000);
        check("wrap_next_valid", 104, {31'b0, bus1.instr_valid_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
